// File: rtl/hpdmc_pkg.sv
// Shared constant functions for the HPDMC single-clock DDR data path.
package hpdmc_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One DQM bit per byte of the two-beat host word.
  function automatic int mask_w(input int dq_width);
    return dq_width / 4;
  endfunction

  // Wide enough to hold BURST_WORDS itself.
  function automatic int spacing_cnt_w(input int burst_words);
    return clog2(burst_words + 1);
  endfunction

endpackage

// File: rtl/hpdmc_ddrdp_if.sv
// Host-side handshakes and PHY-side (ODDR/IDDR) signals of the DDR data path.
interface hpdmc_ddrdp_if
  import hpdmc_pkg::*;
#(
  parameter int DQ_WIDTH = 32
);
  logic                          op_write;
  logic                          op_read;
  logic                          w_valid;
  logic                          w_ready;
  logic [2*DQ_WIDTH-1:0]         w_dat;
  logic [mask_w(DQ_WIDTH)-1:0]   w_mask;
  logic                          r_valid;
  logic                          r_ready;
  logic [2*DQ_WIDTH-1:0]         r_dat;
  logic [2*DQ_WIDTH-1:0]         phy_dq_o;
  logic [mask_w(DQ_WIDTH)-1:0]   phy_dqm_o;
  logic                          phy_dq_oe;
  logic                          phy_dqs_oe;
  logic [2*DQ_WIDTH-1:0]         phy_dq_i;
  logic                          err_clr;
  logic                          wr_underflow;
  logic                          rd_overflow;
  logic                          cmd_err;

  modport master (
    output op_write, op_read, w_valid, w_dat, w_mask, r_ready, phy_dq_i, err_clr,
    input  w_ready, r_valid, r_dat, phy_dq_o, phy_dqm_o, phy_dq_oe, phy_dqs_oe,
           wr_underflow, rd_overflow, cmd_err
  );

  modport slave (
    input  op_write, op_read, w_valid, w_dat, w_mask, r_ready, phy_dq_i, err_clr,
    output w_ready, r_valid, r_dat, phy_dq_o, phy_dqm_o, phy_dq_oe, phy_dqs_oe,
           wr_underflow, rd_overflow, cmd_err
  );
endinterface

// File: rtl/hpdmc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with free-running wrapped pointers.
module hpdmc_sync_fifo
  import hpdmc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_dat,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_dat,
  output logic [clog2(DEPTH):0]     count
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign count   = wp - rp;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wp == rp);
  // A pop at full frees the slot a simultaneous push needs; empty never bypasses.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rp[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/hpdmc_ddrdp.sv
// HPDMC single-clock DDR data path: write/read burst FIFOs, latency pipes,
// command spacing and sticky error flags in front of vendor ODDR/IDDR cells.
module hpdmc_ddrdp
  import hpdmc_pkg::*;
#(
  parameter int DQ_WIDTH    = 32,
  parameter int BURST_WORDS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int WR_LAT      = 1,
  parameter int RD_LAT      = 3
) (
  input logic           clk,
  input logic           rst,
  hpdmc_ddrdp_if.slave  bus
);
  localparam int DW = 2 * DQ_WIDTH;
  localparam int MW = mask_w(DQ_WIDTH);
  localparam int CW = spacing_cnt_w(BURST_WORDS);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_WORDS);
  localparam logic [CW-1:0] BURST_M1  = CW'(BURST_WORDS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  logic [CW-1:0] space_cnt;
  logic          wr_acc;
  logic          rd_acc;
  logic          cmd_bad;
  logic          wr_pre;
  logic          rd_start;
  logic [CW-1:0] wr_left;
  logic [CW-1:0] rd_left;
  logic          wr_active;
  logic          rd_cap;

  // Commands need BURST_WORDS idle cycles since the last accepted one; a
  // simultaneous read and write is a collision and both are dropped.
  assign wr_acc  = bus.op_write && !bus.op_read && (space_cnt == '0) && !rst;
  assign rd_acc  = bus.op_read && !bus.op_write && (space_cnt == '0) && !rst;
  assign cmd_bad = (bus.op_write || bus.op_read) && !(wr_acc || rd_acc);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   space_cnt <= '0;
    else if (wr_acc || rd_acc) space_cnt <= BURST_M1;
    else if (space_cnt != '0)  space_cnt <= space_cnt - 1'b1;
  end

  // Write pipe ends one cycle early so wr_pre can serve as the DQS preamble.
  generate
    if (WR_LAT == 1) begin : g_wr_nodly
      assign wr_pre = wr_acc;
    end else begin : g_wr_dly
      logic [WR_LAT-2:0] wr_sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_sr <= '0;
        else     wr_sr <= (wr_sr << 1) | (WR_LAT-1)'(wr_acc);
      end
      assign wr_pre = wr_sr[WR_LAT-2];
    end
  endgenerate

  logic [RD_LAT-1:0] rd_sr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_sr <= '0;
    else     rd_sr <= (rd_sr << 1) | RD_LAT'(rd_acc);
  end
  assign rd_start = rd_sr[RD_LAT-1];

  // Beat counters: a new start may land on the last beat of the previous burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_left <= '0;
      rd_left <= '0;
    end else begin
      if (wr_pre)              wr_left <= BURST_CNT;
      else if (wr_left != '0)  wr_left <= wr_left - 1'b1;
      if (rd_start)            rd_left <= BURST_M1;
      else if (rd_left != '0)  rd_left <= rd_left - 1'b1;
    end
  end
  assign wr_active = (wr_left != '0);
  assign rd_cap    = rd_start || (rd_left != '0);

  logic [DW+MW-1:0] wf_out;
  logic [AW:0]      wf_count;
  logic             wf_empty;
  logic             wf_pop;
  logic [DW-1:0]    rf_out;
  logic [AW:0]      rf_count;
  logic             rf_empty;
  logic             rf_full;
  logic             rf_pop;

  assign wf_empty    = (wf_count == '0);
  assign wf_pop      = wr_active && !wf_empty;
  assign bus.w_ready = !rst && (wf_count != FIFO_FULL);

  hpdmc_sync_fifo #(.WIDTH(DW + MW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.w_valid && bus.w_ready),
    .push_dat ({bus.w_mask, bus.w_dat}),
    .pop      (wf_pop),
    .pop_dat  (wf_out),
    .count    (wf_count)
  );

  // An empty FIFO at a scheduled beat masks every byte but keeps the burst going.
  assign bus.phy_dq_o   = wf_pop ? wf_out[DW-1:0]     : '0;
  assign bus.phy_dqm_o  = wf_pop ? wf_out[DW+MW-1:DW] : '1;
  assign bus.phy_dq_oe  = wr_active;
  assign bus.phy_dqs_oe = wr_active || wr_pre;

  assign rf_empty    = (rf_count == '0);
  assign rf_full     = (rf_count == FIFO_FULL);
  assign rf_pop      = bus.r_ready && !rf_empty;
  assign bus.r_valid = !rf_empty;
  assign bus.r_dat   = rf_out;

  hpdmc_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_cap),
    .push_dat (bus.phy_dq_i),
    .pop      (rf_pop),
    .pop_dat  (rf_out),
    .count    (rf_count)
  );

  // Sticky flags: a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_underflow <= 1'b0;
      bus.rd_overflow  <= 1'b0;
      bus.cmd_err      <= 1'b0;
    end else begin
      bus.wr_underflow <= (wr_active && wf_empty)          || (bus.wr_underflow && !bus.err_clr);
      bus.rd_overflow  <= (rd_cap && rf_full && !rf_pop)   || (bus.rd_overflow  && !bus.err_clr);
      bus.cmd_err      <= cmd_bad                          || (bus.cmd_err      && !bus.err_clr);
    end
  end
endmodule

// File: tb/tb_hpdmc_ddrdp.sv
// Self-checking bench for hpdmc_ddrdp: directed scenarios plus a random phase,
// all scored against a cycle-indexed event-schedule model.
module tb_hpdmc_ddrdp;
  localparam int DQ    = 32;
  localparam int DW    = 2 * DQ;
  localparam int MW    = DQ / 4;
  localparam int BW    = 4;
  localparam int DEPTH = 8;
  localparam int WL    = 1;
  localparam int RL    = 3;
  localparam int NCYC  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdmc_ddrdp_if #(.DQ_WIDTH(DQ)) bus ();

  hpdmc_ddrdp #(
    .DQ_WIDTH(DQ), .BURST_WORDS(BW), .FIFO_DEPTH(DEPTH), .WR_LAT(WL), .RD_LAT(RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queues for the FIFOs, per-cycle schedules for bursts.
  typedef struct packed {
    logic [MW-1:0] m;
    logic [DW-1:0] d;
  } wword_t;

  wword_t        wq[$];
  logic [DW-1:0] rq[$];
  bit            drv_at [NCYC];
  bit            dqs_at [NCYC];
  bit            cap_at [NCYC];
  int            cyc;
  int            last_acc;
  bit            m_unf, m_ovf, m_cerr;

  logic [DW-1:0] obs_dq   [NCYC];
  logic [MW-1:0] obs_dqm  [NCYC];
  logic          obs_dqoe [NCYC];
  logic          obs_dqs  [NCYC];
  logic          obs_rv   [NCYC];
  logic [DW-1:0] obs_rdat [NCYC];
  logic [DW-1:0] obs_dqi  [NCYC];

  task automatic model_reset();
    wq.delete();
    rq.delete();
    for (int i = 0; i < NCYC; i++) begin
      drv_at[i] = 1'b0;
      dqs_at[i] = 1'b0;
      cap_at[i] = 1'b0;
    end
    m_unf    = 1'b0;
    m_ovf    = 1'b0;
    m_cerr   = 1'b0;
    last_acc = -100;
  endtask

  // One clock cycle: score outputs at negedge, advance the model, step past posedge.
  task automatic cycle();
    bit            acc_w, acc_r, cset, uset, oset, e_drv, popping, w_push;
    logic [DW-1:0] e_dq;
    logic [MW-1:0] e_dqm;
    @(negedge clk);
    acc_w = bus.op_write && !bus.op_read && (cyc - last_acc >= BW);
    acc_r = bus.op_read && !bus.op_write && (cyc - last_acc >= BW);
    cset  = (bus.op_write || bus.op_read) && !acc_w && !acc_r;
    if (acc_w) begin
      last_acc = cyc;
      for (int i = 0; i < BW; i++)  drv_at[cyc + WL + i] = 1'b1;
      for (int i = -1; i < BW; i++) dqs_at[cyc + WL + i] = 1'b1;
    end
    if (acc_r) begin
      last_acc = cyc;
      for (int i = 0; i < BW; i++) cap_at[cyc + RL + i] = 1'b1;
    end
    e_drv = drv_at[cyc];
    uset  = e_drv && (wq.size() == 0);
    e_dq  = '0;
    e_dqm = '1;
    if (e_drv && wq.size() > 0) begin
      e_dq  = wq[0].d;
      e_dqm = wq[0].m;
    end

    obs_dq[cyc]   = bus.phy_dq_o;
    obs_dqm[cyc]  = bus.phy_dqm_o;
    obs_dqoe[cyc] = bus.phy_dq_oe;
    obs_dqs[cyc]  = bus.phy_dqs_oe;
    obs_rv[cyc]   = bus.r_valid;
    obs_rdat[cyc] = bus.r_dat;
    obs_dqi[cyc]  = bus.phy_dq_i;

    check("dq_oe",   bus.phy_dq_oe,  e_drv);
    check("dqs_oe",  bus.phy_dqs_oe, dqs_at[cyc]);
    check("dq_o",    bus.phy_dq_o,   e_dq);
    check("dqm_o",   bus.phy_dqm_o,  e_dqm);
    check("w_ready", bus.w_ready,    wq.size() < DEPTH);
    check("r_valid", bus.r_valid,    rq.size() > 0);
    if (rq.size() > 0) check("r_dat", bus.r_dat, rq[0]);
    check("wr_underflow", bus.wr_underflow, m_unf);
    check("rd_overflow",  bus.rd_overflow,  m_ovf);
    check("cmd_err",      bus.cmd_err,      m_cerr);

    w_push = bus.w_valid && (wq.size() < DEPTH);
    if (e_drv && wq.size() > 0) void'(wq.pop_front());
    if (w_push) wq.push_back('{m: bus.w_mask, d: bus.w_dat});

    popping = bus.r_ready && (rq.size() > 0);
    oset    = 1'b0;
    if (cap_at[cyc] && !(rq.size() < DEPTH || popping)) oset = 1'b1;
    if (popping) void'(rq.pop_front());
    if (cap_at[cyc] && !oset) rq.push_back(bus.phy_dq_i);

    m_unf  = uset || (m_unf  && !bus.err_clr);
    m_ovf  = oset || (m_ovf  && !bus.err_clr);
    m_cerr = cset || (m_cerr && !bus.err_clr);
    cyc++;
    @(posedge clk);
    #1;
    bus.phy_dq_i = {$urandom(), $urandom()};
  endtask

  task automatic idle(input int n);
    bus.op_write = 1'b0;
    bus.op_read  = 1'b0;
    bus.w_valid  = 1'b0;
    bus.err_clr  = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.w_valid = 1'b1;
    bus.w_dat   = d;
    bus.w_mask  = m;
    cycle();
    bus.w_valid = 1'b0;
  endtask

  task automatic pulse(input bit wr, input bit rd);
    bus.op_write = wr;
    bus.op_read  = rd;
    cycle();
    bus.op_write = 1'b0;
    bus.op_read  = 1'b0;
  endtask

  initial begin
    int t;
    bus.op_write = 1'b0;
    bus.op_read  = 1'b0;
    bus.w_valid  = 1'b0;
    bus.w_dat    = '0;
    bus.w_mask   = '0;
    bus.r_ready  = 1'b0;
    bus.err_clr  = 1'b0;
    bus.phy_dq_i = '0;
    cyc = 0;
    model_reset();

    // Reset values while rst is held.
    #12;
    check("rst_w_ready", bus.w_ready,    1'b0);
    check("rst_r_valid", bus.r_valid,    1'b0);
    check("rst_dq_o",    bus.phy_dq_o,   64'h0);
    check("rst_dqm_o",   bus.phy_dqm_o,  8'hff);
    check("rst_dq_oe",   bus.phy_dq_oe,  1'b0);
    check("rst_dqs_oe",  bus.phy_dqs_oe, 1'b0);
    check("rst_flags",   {bus.wr_underflow, bus.rd_overflow, bus.cmd_err}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed write burst 0x11..0x44, WR_LAT=1.
    for (int i = 1; i <= 4; i++) push_word(64'h11 * i, '0);
    t = cyc;
    pulse(1'b1, 1'b0);
    idle(6);
    for (int i = 1; i <= 4; i++) begin
      check("wb_dq", obs_dq[t + i], 64'h11 * i);
      check("wb_dq_oe", obs_dqoe[t + i], 1'b1);
    end
    check("wb_dq_oe_pre",  obs_dqoe[t],     1'b0);
    check("wb_dq_oe_post", obs_dqoe[t + 5], 1'b0);
    for (int i = 0; i <= 4; i++) check("wb_dqs_oe", obs_dqs[t + i], 1'b1);
    check("wb_dqs_oe_pre",  obs_dqs[t - 1], 1'b0);
    check("wb_dqs_oe_post", obs_dqs[t + 5], 1'b0);

    // Directed read burst with r_ready held high.
    bus.r_ready = 1'b1;
    t = cyc;
    pulse(1'b0, 1'b1);
    idle(10);
    check("rb_r_valid_early", obs_rv[t + 3], 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("rb_r_valid", obs_rv[t + 4 + i], 1'b1);
      check("rb_r_dat",   obs_rdat[t + 4 + i], obs_dqi[t + 3 + i]);
    end
    check("rb_r_valid_done", obs_rv[t + 8], 1'b0);

    // Underflow: only two words for a four-word burst.
    push_word(64'hdead_0001, 8'h0f);
    push_word(64'hdead_0002, 8'h00);
    t = cyc;
    pulse(1'b1, 1'b0);
    idle(6);
    check("uf_dq_beat3",  obs_dq[t + 3],  64'h0);
    check("uf_dqm_beat3", obs_dqm[t + 3], 8'hff);
    check("uf_dqm_beat1", obs_dqm[t + 1], 8'h0f);
    check("uf_flag", bus.wr_underflow, 1'b1);
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    check("uf_cleared", bus.wr_underflow, 1'b0);

    // Overflow: three read bursts with nothing draining the read FIFO.
    bus.r_ready = 1'b0;
    pulse(1'b0, 1'b1);
    idle(3);
    pulse(1'b0, 1'b1);
    idle(3);
    pulse(1'b0, 1'b1);
    idle(10);
    check("of_flag", bus.rd_overflow, 1'b1);
    bus.r_ready = 1'b1;
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    idle(10);
    check("of_drained", bus.r_valid, 1'b0);

    // Spacing: read two cycles after a write is rejected, at four it is taken.
    bus.r_ready = 1'b0;
    t = cyc;
    pulse(1'b1, 1'b0);
    idle(1);
    pulse(1'b0, 1'b1);
    check("sp_cmd_err", bus.cmd_err, 1'b1);
    idle(1);
    pulse(1'b0, 1'b1);
    idle(6);
    check("sp_r_valid_pre", obs_rv[t + 7], 1'b0);
    check("sp_r_valid",     obs_rv[t + 8], 1'b1);
    bus.r_ready = 1'b1;
    bus.err_clr = 1'b1;
    cycle();
    idle(8);

    // Collision: both commands in one cycle are ignored and flagged.
    t = cyc;
    pulse(1'b1, 1'b1);
    idle(5);
    check("col_no_dqs", obs_dqs[t + 1], 1'b0);
    check("col_cmd_err", bus.cmd_err, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bus.op_write = ($urandom_range(0, 5) == 0);
      bus.op_read  = ($urandom_range(0, 5) == 0);
      bus.w_valid  = ($urandom_range(0, 2) != 0);
      bus.w_dat    = {$urandom(), $urandom()};
      bus.w_mask   = MW'($urandom());
      bus.r_ready  = ($urandom_range(0, 3) != 0);
      bus.err_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle(12);

    // Reset during beat 2 of a write burst, with read data also pending.
    bus.r_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word({$urandom(), $urandom()}, '0);
    pulse(1'b0, 1'b1);
    idle(7);
    pulse(1'b1, 1'b0);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_dq_oe",   bus.phy_dq_oe,  1'b0);
    check("mr_dqs_oe",  bus.phy_dqs_oe, 1'b0);
    check("mr_dq_o",    bus.phy_dq_o,   64'h0);
    check("mr_dqm_o",   bus.phy_dqm_o,  8'hff);
    check("mr_w_ready", bus.w_ready,    1'b0);
    check("mr_r_valid", bus.r_valid,    1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(8);
    bus.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word({$urandom(), $urandom()}, MW'($urandom()));
    pulse(1'b1, 1'b0);
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hpdmc_ddrdp.md
# hpdmc_ddrdp

Parametrised single-clock DDR data path for HPDMC. It replaces the clk2x/DQS-clocked I/O block. It sits between the HPDMC command sequencer and the vendor ODDR/IDDR/IOBUF primitives, which perform all double-rate conversion. The block buffers host write data in a FIFO and drives one write burst per op_write after a programmable write latency. It captures one read burst per op_read after a programmable read latency into a FIFO drained with valid/ready. It flags underflow, overflow and command collisions.

## Interface
- DQ_WIDTH, 32: SDRAM DQ pins; multiple of 8.
- BURST_WORDS, 4: host words per burst; each word is one clk cycle, i.e. two DQ beats.
- FIFO_DEPTH, 8: words per FIFO; power of 2, ≥ BURST_WORDS.
- WR_LAT, 1: cycles from op_write to first driven word; 1..15.
- RD_LAT, 3: cycles from op_read to first valid phy_dq_i word; 1..15.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- op_write  in  1  write burst command, one-cycle pulse.
- op_read  in  1  read burst command, one-cycle pulse.
- w_valid / w_ready  in / out  1  write FIFO push handshake.
- w_dat  in  2*DQ_WIDTH  write word; [DQ_WIDTH-1:0] is the first beat.
- w_mask  in  DQ_WIDTH/4  byte masks; 1 = byte not written.
- r_valid / r_ready  out / in  1  read FIFO pop handshake, first-word-fall-through.
- r_dat  out  2*DQ_WIDTH  read word; low half is the first beat.
- phy_dq_o  out  2*DQ_WIDTH  to ODDR; low half on rising edge.
- phy_dqm_o  out  DQ_WIDTH/4  to ODDR.
- phy_dq_oe, phy_dqs_oe  out  1  DQ and DQS tristate enables.
- phy_dq_i  in  2*DQ_WIDTH  from IDDR; low half is the rising-edge beat.
- err_clr  in  1  clears all sticky flags.
- wr_underflow, rd_overflow, cmd_err  out  1  sticky error flags.

## Operation
- Write FIFO push on w_valid&&w_ready. w_ready = !full.
- op_write at cycle T: words pop on cycles T+WR_LAT .. T+WR_LAT+BURST_WORDS-1.
  - Each popped word drives phy_dq_o and phy_dqm_o, with phy_dq_oe=1.
  - phy_dqs_oe=1 from T+WR_LAT-1 (preamble) through the last word.
- Write FIFO empty at a scheduled beat: phy_dq_o=0, phy_dqm_o all ones, wr_underflow set, burst continues.
- op_read at T: phy_dq_i is pushed into the read FIFO on cycles T+RD_LAT .. T+RD_LAT+BURST_WORDS-1.
  - Read FIFO full at a capture: word dropped, rd_overflow set.
- r_valid = !empty. Pop on r_valid&&r_ready.
- Command spacing: a command is accepted only if ≥ BURST_WORDS cycles have passed since the last accepted command of either type.
  - op_read and op_write in the same cycle are both ignored.
  - Violation: command ignored, cmd_err set.
- Read and write latency pipelines are independent. A read capture may overlap a write drive.
- err_clr clears the flags. If err_clr and a new error occur in the same cycle, the flag stays set.

## Timing
- Reset values: w_ready=0 while rst is high, 1 on the first cycle after. r_valid=0, phy_dq_o=0, phy_dqm_o all ones, both oe=0, all flags 0. Both FIFOs empty, pending bursts cleared.
- Reset mid-burst: outputs return to reset values asynchronously; no partial completion after release.
- Idle (no burst active): phy_dq_o=0, phy_dqm_o all ones, oe=0.
- Push-to-drive: a word pushed at cycle k can be driven at k+1.
- Capture-to-r_valid: a word captured at cycle k gives r_valid at k+1.
- Same-cycle push and pop: allowed on both FIFOs at any fill level, including full (write FIFO: pop frees the slot) and empty (read FIFO: no bypass).
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap freely.

## Structure
- hpdmc_pkg holds:
  - localparam functions clog2 and mask width (DQ_WIDTH/4);
  - the command-spacing counter width constant.
- Sub-module hpdmc_sync_fifo (WIDTH, DEPTH; FWFT, count output) is instantiated twice:
  - write FIFO, width 2*DQ_WIDTH+DQ_WIDTH/4;
  - read FIFO, width 2*DQ_WIDTH.
- Top level contains:
  - the two latency shift registers (op_write for WR_LAT-1 cycles, op_read for RD_LAT);
  - two beat counters;
  - the spacing counter;
  - the flag logic.

## Test plan
- Write burst: push 4 words 0x11..0x44 (mask 0); op_write at T with WR_LAT=1 -> phy_dq_o = 0x11..0x44 on T+1..T+4; dq_oe high exactly then; dqs_oe high T..T+4.
- Read burst: op_read at T with RD_LAT=3; phy_dq_i = A,B,C,D on T+3..T+6 -> r_valid from T+4; r_ready held 1 pops A,B,C,D in order.
- Underflow: 2 words pushed, op_write -> beats 3 and 4 drive data 0 with dqm all ones; wr_underflow=1 until err_clr.
- Overflow: 3 read bursts with r_ready=0 (FIFO_DEPTH=8) -> 8 words stored, 4 dropped, rd_overflow=1.
- Spacing: op_write at T, op_read at T+2 -> read ignored, cmd_err=1. op_read at T+4 -> accepted.
- Reset: assert rst at beat 2 of a write burst -> oe drop immediately; FIFOs empty; next burst after release is clean.
